// File: rtl/tick_pkg.sv
// Shared types and elaboration helpers for the tick sequencer.
package tick_pkg;

    typedef enum logic [1:0] {
        OP_STOP  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_STEP = 2'b11
    } state_e;

    // Accumulator must hold acc + rate, which stays below 2*ref_hz.
    function automatic int unsigned acc_width(input longint unsigned ref_hz);
        return $clog2(64'd2 * ref_hz);
    endfunction

    function automatic logic [63:0] clamp_rate(input logic [63:0] tps, input logic [63:0] limit);
        return (tps > limit) ? limit : tps;
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Modulo-REF_CLK_HZ phase accumulator; flags the wrap and the half-period crossing combinationally.
module phase_accumulator #(
    parameter int unsigned REF_CLK_HZ = 50_000_000,
    parameter int unsigned ACC_W      = 27
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_rate,
    output logic             o_tick,
    output logic             o_half
);

    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(REF_CLK_HZ);
    localparam logic [ACC_W-1:0] HALF    = ACC_W'(REF_CLK_HZ / 2);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;

    assign sum    = acc_q + i_rate;
    assign o_tick = i_en && (sum >= MODULUS);
    // A wrap always leaves the residue below HALF because the rate never exceeds HALF.
    assign o_half = i_en && !o_tick && (sum >= HALF);

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (o_tick) begin
            acc_d = sum - MODULUS;
        end else if (i_en) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// Redstone tick generator: run/stop/single-step control, tick strobe, square tick clock and tick counter.
module tick_sequencer
    import tick_pkg::*;
#(
    parameter int unsigned REF_CLK_HZ = 50_000_000,
    parameter int unsigned TPS_WIDTH  = 32,
    parameter int unsigned STEP_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [TPS_WIDTH-1:0]  i_tps,
    input  logic                  i_cmd_valid,
    input  logic [1:0]            i_cmd_op,
    input  logic [STEP_WIDTH-1:0] i_cmd_arg,
    output logic                  o_cmd_ready,
    output logic                  o_tick,
    output logic                  o_tick_clk,
    output logic [CNT_WIDTH-1:0]  o_tick_count,
    output logic                  o_step_done,
    output logic [1:0]            o_state
);

    localparam int unsigned ACC_W    = acc_width(64'(REF_CLK_HZ));
    localparam logic [63:0] RATE_MAX = 64'(REF_CLK_HZ / 2);

    state_e                state_q, state_d;
    logic                  mode_step_q, mode_step_d;
    logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  tick_q, tick_d;
    logic                  tclk_q, tclk_d;
    logic                  done_q, done_d;

    op_e              op;
    logic             cmd_ready, cmd_fire, active, leaving;
    logic             acc_clr, wrap, half, tick_fire;
    logic [ACC_W-1:0] rate;

    assign op        = op_e'(i_cmd_op);
    assign cmd_ready = (state_q != ST_ARM);
    assign cmd_fire  = i_cmd_valid && cmd_ready;
    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign rate      = ACC_W'(clamp_rate(64'(i_tps), RATE_MAX));
    assign leaving   = active && ((state_d == ST_IDLE) || (state_d == ST_ARM));
    assign acc_clr   = (state_q == ST_ARM) || leaving;
    // A wrap coinciding with STOP or a re-arm is dropped, not issued.
    assign tick_fire = wrap && !acc_clr;

    phase_accumulator #(
        .REF_CLK_HZ (REF_CLK_HZ),
        .ACC_W      (ACC_W)
    ) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (acc_clr),
        .i_en    (active),
        .i_rate  (rate),
        .o_tick  (wrap),
        .o_half  (half)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (op == OP_RUN)) begin
                    state_d = ST_ARM;
                end else if (cmd_fire && (op == OP_STEP) && (i_cmd_arg != '0)) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: state_d = mode_step_q ? ST_STEP : ST_RUN;
            default: begin
                if (cmd_fire && (op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end else if (cmd_fire && (op == OP_RUN) && (state_q == ST_STEP)) begin
                    state_d = ST_ARM;
                end else if (cmd_fire && (op == OP_STEP)) begin
                    state_d = (i_cmd_arg != '0) ? ST_ARM : ST_IDLE;
                end else if ((state_q == ST_STEP) && done_q) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        o_cmd_ready  = cmd_ready;
        o_tick       = tick_q;
        o_tick_clk   = tclk_q;
        o_tick_count = count_q;
        o_step_done  = done_q;
        o_state      = state_q;
    end

    always_comb begin
        mode_step_d = mode_step_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        tick_d      = tick_fire;
        done_d      = 1'b0;
        tclk_d      = tclk_q;
        if (tick_fire) begin
            tclk_d = 1'b1;
        end else if (half) begin
            tclk_d = 1'b0;
        end
        if ((state_d == ST_IDLE) || (state_d == ST_ARM)) begin
            tclk_d = 1'b0;
        end
        if (tick_fire && (state_q == ST_STEP) && (remaining_q != '0)) begin
            remaining_d = remaining_q - STEP_WIDTH'(1);
            done_d      = (remaining_q == STEP_WIDTH'(1));
        end
        if (cmd_fire && (op == OP_STEP)) begin
            mode_step_d = 1'b1;
            remaining_d = i_cmd_arg;
            done_d      = (i_cmd_arg == '0);
        end
        if (cmd_fire && (op == OP_RUN)) begin
            mode_step_d = 1'b0;
        end
        if (tick_fire) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
        if (cmd_fire && (op == OP_CLEAR)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_step_q <= 1'b0;
            remaining_q <= '0;
            count_q     <= '0;
            tick_q      <= 1'b0;
            tclk_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mode_step_q <= mode_step_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            tclk_q      <= tclk_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer at REF_CLK_HZ=100 with a 4-bit tick counter.
module tb_tick_sequencer;

    localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLEAR = 2'd3;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_STEP = 2'd3;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [15:0] arg;
        logic [31:0] tps;
        logic        e_tick;
        logic        e_tclk;
        logic [3:0]  e_cnt;
        logic        e_done;
        logic [1:0]  e_state;
        logic        e_rdy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tps = '0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [15:0] cmd_arg = '0;
    logic        cmd_ready, tick, tick_clk, step_done;
    logic [3:0]  tick_count;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    tick_sequencer #(
        .REF_CLK_HZ (100),
        .TPS_WIDTH  (32),
        .STEP_WIDTH (16),
        .CNT_WIDTH  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tps        (tps),
        .i_cmd_valid  (cmd_valid),
        .i_cmd_op     (cmd_op),
        .i_cmd_arg    (cmd_arg),
        .o_cmd_ready  (cmd_ready),
        .o_tick       (tick),
        .o_tick_clk   (tick_clk),
        .o_tick_count (tick_count),
        .o_step_done  (step_done),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_tick, input logic e_tclk,
                           input logic [3:0] e_cnt, input logic e_done,
                           input logic [1:0] e_state, input logic e_rdy);
        chk({tag, ".tick"},  32'(tick),       32'(e_tick));
        chk({tag, ".tclk"},  32'(tick_clk),   32'(e_tclk));
        chk({tag, ".count"}, 32'(tick_count), 32'(e_cnt));
        chk({tag, ".done"},  32'(step_done),  32'(e_done));
        chk({tag, ".state"}, 32'(state),      32'(e_state));
        chk({tag, ".ready"}, 32'(cmd_ready),  32'(e_rdy));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step();
        cmd_valid = 1'b0;
        $display("cmd op=%0d arg=%0d -> state=%0d count=%0d", op, arg, state, tick_count);
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic [15:0] arg,
                                input logic [31:0] r, input logic et, input logic ec,
                                input logic [3:0] en, input logic ed, input logic [1:0] es,
                                input logic er);
        vec_t x;
        x.valid = v; x.op = op; x.arg = arg; x.tps = r;
        x.e_tick = et; x.e_tclk = ec; x.e_cnt = en; x.e_done = ed; x.e_state = es; x.e_rdy = er;
        return x;
    endfunction

    initial begin
        int ticks;
        int dones;
        logic found;

        // RUN at 25 tps: first tick 5 cycles into RUN, then every 4, clock high 2 / low 2.
        vecs.push_back(mk(1, OP_RUN,  0, 25, 0, 0, 0, 0, S_ARM, 0));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 0, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 0, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 0, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 0, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 1, 1, 1, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 1, 1, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 1, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 1, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 1, 1, 2, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 1, 2, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 2, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 0, 0, 2, 0, S_RUN, 1));
        vecs.push_back(mk(0, OP_STOP, 0, 25, 1, 1, 3, 0, S_RUN, 1));
        vecs.push_back(mk(1, OP_STOP, 0, 25, 0, 0, 3, 0, S_IDLE, 1));
        // CLEAR, then STEP 3 at 50 tps: ticks 2 apart, done with the third tick.
        vecs.push_back(mk(1, OP_CLEAR, 0, 50, 0, 0, 0, 0, S_IDLE, 1));
        vecs.push_back(mk(1, OP_STEP,  3, 50, 0, 0, 0, 0, S_ARM, 0));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 0, 0, 0, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 0, 0, 0, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 1, 1, 1, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 0, 0, 1, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 1, 1, 2, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 0, 0, 2, 0, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 1, 1, 3, 1, S_STEP, 1));
        vecs.push_back(mk(0, OP_STOP,  0, 50, 0, 0, 3, 0, S_IDLE, 1));

        // Reset state.
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, S_IDLE, 1);
        rst_n = 1'b1;
        step();
        chk_all("post_reset", 0, 0, 0, 0, S_IDLE, 1);

        foreach (vecs[i]) begin
            cmd_valid = vecs[i].valid;
            cmd_op    = vecs[i].op;
            cmd_arg   = vecs[i].arg;
            tps       = vecs[i].tps;
            step();
            $display("vec %0d: tick=%0d tclk=%0d cnt=%0d done=%0d state=%0d rdy=%0d",
                     i, tick, tick_clk, tick_count, step_done, state, cmd_ready);
            chk_all($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_tclk, vecs[i].e_cnt,
                    vecs[i].e_done, vecs[i].e_state, vecs[i].e_rdy);
        end
        cmd_valid = 1'b0;

        // STEP 10 interrupted by STOP right after the second tick.
        cmd(OP_CLEAR, 0);
        tps = 50;
        cmd(OP_STEP, 10);
        ticks = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick) ticks++;
            if (ticks == 2) found = 1'b1;
        end
        chk("t4_second_tick_seen", 32'(found), 1);
        cmd(OP_STOP, 0);
        chk_all("t4_after_stop", 0, 0, 2, 0, S_IDLE, 1);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) ticks++;
            if (step_done) dones++;
        end
        chk("t4_no_more_ticks", 32'(ticks), 0);
        chk("t4_no_done", 32'(dones), 0);
        chk("t4_count", 32'(tick_count), 2);

        // Zero rate holds, then an over-range rate is clamped to REF/2.
        cmd(OP_CLEAR, 0);
        tps = 0;
        cmd(OP_RUN, 0);
        ticks = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (tick) ticks++;
        end
        chk("t5_zero_rate_ticks", 32'(ticks), 0);
        chk("t5_zero_rate_state", 32'(state), 32'(S_RUN));
        tps = 500;
        for (int i = 0; i < 8; i++) begin
            step();
            $display("t5 cycle %0d: tick=%0d tclk=%0d cnt=%0d", i, tick, tick_clk, tick_count);
            chk($sformatf("t5_tick%0d", i), 32'(tick), 32'(i % 2));
            chk($sformatf("t5_tclk%0d", i), 32'(tick_clk), 32'(i % 2));
        end
        chk("t5_count", 32'(tick_count), 4);
        cmd(OP_STOP, 0);

        // 4-bit counter wrap, CLEAR coincident with an increment, STEP 0.
        cmd(OP_CLEAR, 0);
        tps = 50;
        cmd(OP_RUN, 0);
        ticks = 0;
        for (int i = 0; i < 60 && ticks < 17; i++) begin
            step();
            if (tick) begin
                ticks++;
                chk($sformatf("t6_wrap_count%0d", ticks), 32'(tick_count), 32'(ticks % 16));
            end
        end
        chk("t6_ticks_seen", 32'(ticks), 17);
        step();
        cmd(OP_CLEAR, 0);
        chk("t6_clear_tick", 32'(tick), 1);
        chk("t6_clear_wins", 32'(tick_count), 0);
        step();
        step();
        chk("t6_next_tick", 32'(tick), 1);
        chk("t6_count_after_clear", 32'(tick_count), 1);
        cmd(OP_STOP, 0);
        cmd(OP_STEP, 0);
        chk_all("t6_step0", 0, 0, 1, 1, S_IDLE, 1);
        step();
        chk("t6_step0_done_clears", 32'(step_done), 0);

        // Asynchronous reset in the middle of RUN.
        tps = 25;
        cmd(OP_RUN, 0);
        for (int i = 0; i < 5; i++) step();
        chk("t1_pre_tclk", 32'(tick_clk), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("t1_in_reset", 0, 0, 0, 0, S_IDLE, 1);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_all("t1_released", 0, 0, 0, 0, S_IDLE, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tick_sequencer.md
Name: tick_sequencer

Overview:
- Parametrised successor to the fixed TPS divider. Generates redstone ticks from the system clock using a phase accumulator, which gives fractional-rate-accurate tick spacing.
- Adds run/stop/single-step modes, a tick counter and a command handshake driven by command_controller.
- Sits between command_controller and RoC. Drives both a one-cycle tick strobe and a square tick clock.

Parameters:
- REF_CLK_HZ, 50_000_000, system clock frequency and accumulator modulus
- TPS_WIDTH, 32, width of requested ticks-per-second
- STEP_WIDTH, 16, width of step-count argument
- CNT_WIDTH, 32, width of free-running tick counter

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_tps  in  TPS_WIDTH  requested tick rate, sampled every cycle
- i_cmd_valid  in  1  command present
- i_cmd_op  in  2  00 STOP, 01 RUN, 10 STEP, 11 CLEAR
- i_cmd_arg  in  STEP_WIDTH  step count, used by STEP only
- o_cmd_ready  out  1  command accepted when valid&&ready
- o_tick  out  1  one-cycle strobe per tick
- o_tick_clk  out  1  square tick clock, rising edge aligned with o_tick
- o_tick_count  out  CNT_WIDTH  ticks issued since reset/CLEAR, wraps modulo 2^CNT_WIDTH
- o_step_done  out  1  one-cycle pulse when a STEP completes
- o_state  out  2  00 IDLE, 01 ARM, 10 RUN, 11 STEP

Behaviour:
- Reset (async assert, sync release): state IDLE, acc=0, remaining=0, all outputs 0 except o_cmd_ready=1.
- Effective rate r = min(i_tps, REF_CLK_HZ/2). The clamp guarantees o_tick_clk can toggle.
- Accumulator, in RUN/STEP each cycle:
  - if acc + r >= REF_CLK_HZ: acc <= acc + r - REF_CLK_HZ; o_tick=1 next cycle.
  - else: acc <= acc + r.
  - Width is ceil(log2(2*REF_CLK_HZ)); no overflow permitted.
- o_tick_clk: set with o_tick; cleared the cycle after acc first reaches >= REF_CLK_HZ/2 following that tick. Forced 0 in IDLE/ARM.
- r=0 in RUN/STEP: no ticks, state held.
- o_cmd_ready = 0 only in ARM.
- IDLE:
  - RUN -> ARM (mode run).
  - STEP with arg>0 -> ARM (remaining=arg).
  - STEP with arg=0 -> stay IDLE, o_step_done pulses next cycle.
  - STOP -> no-op.
- ARM: clears acc and o_tick_clk; lasts exactly 1 cycle; then RUN or STEP.
- RUN: STOP -> IDLE; STEP -> ARM with new remaining; RUN -> no-op.
- STEP:
  - Each tick decrements remaining.
  - On the tick taking remaining 1->0: o_step_done pulses in the same cycle as that o_tick; state -> IDLE.
  - STOP -> IDLE with no o_step_done.
  - RUN -> ARM.
- STOP: acc cleared, in-flight tick suppressed, o_tick_clk low next cycle.
- CLEAR: accepted in any state except ARM. Zeroes o_tick_count, does not change state.
  - CLEAR coincident with a tick increment: clear wins, count=0.
- Latency:
  - RUN accepted at edge T -> ARM during T+1 -> RUN from T+2.
  - First o_tick at the earliest cycle k>=1 in RUN with k*r >= REF_CLK_HZ, plus 1 register stage.
- i_tps change mid-run takes effect on the next accumulation; acc is not reset.

Decomposition:
- tick_pkg holds:
  - op enum (STOP/RUN/STEP/CLEAR)
  - state enum (IDLE/ARM/RUN/STEP)
  - ACC_WIDTH function
  - clamp helper
- Sub-module phase_accumulator: inputs clr, en, rate; outputs tick, half.
- tick_sequencer holds the FSM, step counter and tick counter.

Test Plan:
All scenarios use REF_CLK_HZ=100.
1. Assert i_rst_n=0 mid-RUN -> all outputs 0 immediately, o_cmd_ready=1; after release o_state=IDLE.
2. i_tps=25, RUN -> o_tick every 4 cycles, first at 5th cycle after entering RUN; o_tick_clk high 2/low 2; count 0,1,2,...
3. i_tps=50, STEP arg=3 -> exactly 3 ticks 2 cycles apart; o_step_done coincident with 3rd tick; o_state IDLE next cycle; count=3.
4. STEP arg=10, STOP after 2nd tick -> no further ticks, no o_step_done, count=2, o_tick_clk low next cycle.
5. i_tps=0, RUN -> no ticks for 1000 cycles. Then i_tps=500 -> clamped to 50, ticks every 2 cycles, o_tick_clk toggles each cycle.
6. CNT_WIDTH=4: run 17 ticks -> count wraps 15->0->1. CLEAR on a tick cycle -> count=0. STEP arg=0 -> o_step_done next cycle, no tick.
